// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state encoding,
// the hard-wired zero register index and the stall down-counter width.
package hazard_pkg;

  typedef enum logic {
    HZ_IDLE  = 1'b0,
    HZ_STALL = 1'b1
  } hz_state_e;

  // Register $0 reads as zero, so it never carries a dependency.
  localparam int unsigned REG_ZERO = 0;

  // Wide enough for stall lengths up to 15.
  localparam int unsigned HZ_CNT_W = 4;

endpackage

// File: rtl/hazard_stats.sv
// Optional performance counters for hazard_unit: cycles spent stalling and
// cycles spent flushing. Both counters wrap naturally at 2^32.
module hazard_stats (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        stallCycle,
  input  logic        flushCycle,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
);

  logic [31:0] stall_q, stall_d;
  logic [31:0] flush_q, flush_d;

  // Next-state increments.
  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (stallCycle) stall_d = stall_q + 32'd1;
    if (flushCycle) flush_d = flush_q + 32'd1;
  end

  // Counter registers, cleared by reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard controller for the five-stage core. Detects load-use
// dependencies between EX and ID, stretches the stall to LOAD_STALL_CYCLES
// bubbles, and lets taken branches resolved in MEM override any stall.
// Define HAZARD_UNIT_STATS_EN to add the stall_cycles / flush_count outputs.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int unsigned LOAD_STALL_CYCLES = 1,
  parameter int unsigned REG_AW            = 5
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rt,
  input  logic              ex_MemRead,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic              mem_branch_taken,
  output logic              hazardMux,
  output logic              PCWrite,
  output logic              IFIDWrite,
  output logic              IFIDFlush,
  output logic              EXFlush
`ifdef HAZARD_UNIT_STATS_EN
  ,
  output logic [31:0]       stall_cycles,
  output logic [31:0]       flush_count
`endif
);

  localparam logic [REG_AW-1:0]   RegZero   = REG_AW'(REG_ZERO);
  localparam logic [HZ_CNT_W-1:0] StallLoad = HZ_CNT_W'(LOAD_STALL_CYCLES - 1);
  localparam bit                  MultiStall = (LOAD_STALL_CYCLES > 1);

  hz_state_e           state_q, state_d;
  logic [HZ_CNT_W-1:0] cnt_q, cnt_d;

  logic loadUse;
  logic flush;
  logic stallActive;
  logic stallRule;
  logic flushRule;

  // Load-use detection; rt only matters when the ID instruction reads it.
  always_comb begin
    loadUse = ex_MemRead && (ex_rt != RegZero) &&
              ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
  end

  assign flush       = mem_branch_taken;
  // Once in STALL the length is fixed, so load_use is not consulted there.
  assign stallActive = (state_q == HZ_STALL) || loadUse;
  assign flushRule   = reset_n && flush;
  assign stallRule   = reset_n && !flush && stallActive;

  // Next-state logic: flush wins, otherwise count down the fixed stall.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (flush) begin
      state_d = HZ_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        HZ_IDLE: begin
          if (loadUse && MultiStall) begin
            state_d = HZ_STALL;
            cnt_d   = StallLoad;
          end
        end
        HZ_STALL: begin
          // cnt of 0 is unreachable; treat it like the last cycle for safety.
          if (cnt_q <= HZ_CNT_W'(1)) begin
            state_d = HZ_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - HZ_CNT_W'(1);
          end
        end
        default: begin
          state_d = HZ_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State and counter registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= HZ_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Output decode in priority order: reset, flush, stall, normal.
  always_comb begin
    hazardMux = 1'b0;
    PCWrite   = 1'b1;
    IFIDWrite = 1'b1;
    IFIDFlush = 1'b0;
    EXFlush   = 1'b0;
    if (!reset_n) begin
      // Hold the front end and bubble ID/EX while reset is asserted.
      hazardMux = 1'b1;
      PCWrite   = 1'b0;
      IFIDWrite = 1'b0;
    end else if (flush) begin
      hazardMux = 1'b1;
      IFIDFlush = 1'b1;
      EXFlush   = 1'b1;
    end else if (stallActive) begin
      hazardMux = 1'b1;
      PCWrite   = 1'b0;
      IFIDWrite = 1'b0;
    end
  end

`ifdef HAZARD_UNIT_STATS_EN
  hazard_stats u_stats (
    .clock        (clock),
    .reset_n      (reset_n),
    .stallCycle   (stallRule),
    .flushCycle   (flushRule),
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count)
  );
`else
  // Rule strobes only feed the optional counters.
  logic unusedRules;
  assign unusedRules = stallRule ^ flushRule;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit. Three instances share one set of
// inputs with LOAD_STALL_CYCLES of 1, 3 and 4. Outputs are compared as the
// packed vector {hazardMux, PCWrite, IFIDWrite, IFIDFlush, EXFlush}.
module tb_hazard_unit;

  localparam logic [4:0] ONorm  = 5'b01100;
  localparam logic [4:0] OStall = 5'b10000;
  localparam logic [4:0] OFlush = 5'b11111;
  localparam logic [4:0] ORst   = 5'b10000;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       id_uses_rt, ex_MemRead, mem_branch_taken;

  logic hm1, pc1, iw1, if1, ef1;
  logic hm3, pc3, iw3, if3, ef3;
  logic hm4, pc4, iw4, if4, ef4;
  logic [4:0] o1, o3, o4;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  assign o1 = {hm1, pc1, iw1, if1, ef1};
  assign o3 = {hm3, pc3, iw3, if3, ef3};
  assign o4 = {hm4, pc4, iw4, if4, ef4};

`ifdef HAZARD_UNIT_STATS_EN
  logic [31:0] sc1, fc1, sc3, fc3, sc4, fc4;
`endif

  hazard_unit #(.LOAD_STALL_CYCLES(1), .REG_AW(5)) dut1 (
    .clock(clock), .reset_n(reset_n), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .ex_MemRead(ex_MemRead), .ex_rt(ex_rt),
    .mem_branch_taken(mem_branch_taken), .hazardMux(hm1), .PCWrite(pc1),
    .IFIDWrite(iw1), .IFIDFlush(if1), .EXFlush(ef1)
`ifdef HAZARD_UNIT_STATS_EN
    , .stall_cycles(sc1), .flush_count(fc1)
`endif
  );

  hazard_unit #(.LOAD_STALL_CYCLES(3), .REG_AW(5)) dut3 (
    .clock(clock), .reset_n(reset_n), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .ex_MemRead(ex_MemRead), .ex_rt(ex_rt),
    .mem_branch_taken(mem_branch_taken), .hazardMux(hm3), .PCWrite(pc3),
    .IFIDWrite(iw3), .IFIDFlush(if3), .EXFlush(ef3)
`ifdef HAZARD_UNIT_STATS_EN
    , .stall_cycles(sc3), .flush_count(fc3)
`endif
  );

  hazard_unit #(.LOAD_STALL_CYCLES(4), .REG_AW(5)) dut4 (
    .clock(clock), .reset_n(reset_n), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .ex_MemRead(ex_MemRead), .ex_rt(ex_rt),
    .mem_branch_taken(mem_branch_taken), .hazardMux(hm4), .PCWrite(pc4),
    .IFIDWrite(iw4), .IFIDFlush(if4), .EXFlush(ef4)
`ifdef HAZARD_UNIT_STATS_EN
    , .stall_cycles(sc4), .flush_count(fc4)
`endif
  );

  typedef struct {
    string      name;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rt;
    logic       mem_read;
    logic [4:0] exrt;
    logic       br;
    logic [4:0] exp;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0;
    ex_MemRead = 1'b0; ex_rt = 5'd0; mem_branch_taken = 1'b0;
  endtask

  task automatic set_hazard(input logic br);
    id_rs = 5'd8; id_rt = 5'd0; id_uses_rt = 1'b0;
    ex_MemRead = 1'b1; ex_rt = 5'd8; mem_branch_taken = br;
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic sample();
    @(negedge clock);
  endtask

  task automatic do_reset();
    next_cycle();
    reset_n = 1'b0;
    clear_inputs();
    next_cycle();
    reset_n = 1'b1;
  endtask

  initial begin
    vecs[0] = '{"no_memread",   5'd8,  5'd0,  1'b0, 1'b0, 5'd8,  1'b0, ONorm};
    vecs[1] = '{"rs_match",     5'd8,  5'd0,  1'b0, 1'b1, 5'd8,  1'b0, OStall};
    vecs[2] = '{"rt_unused",    5'd3,  5'd8,  1'b0, 1'b1, 5'd8,  1'b0, ONorm};
    vecs[3] = '{"rt_used",      5'd3,  5'd8,  1'b1, 1'b1, 5'd8,  1'b0, OStall};
    vecs[4] = '{"zero_rs",      5'd0,  5'd0,  1'b0, 1'b1, 5'd0,  1'b0, ONorm};
    vecs[5] = '{"zero_rt",      5'd4,  5'd0,  1'b1, 1'b1, 5'd0,  1'b0, ONorm};
    vecs[6] = '{"hazard_flush", 5'd8,  5'd0,  1'b0, 1'b1, 5'd8,  1'b1, OFlush};
    vecs[7] = '{"plain_flush",  5'd1,  5'd2,  1'b1, 1'b0, 5'd9,  1'b1, OFlush};
    vecs[8] = '{"rs_match_31",  5'd31, 5'd0,  1'b0, 1'b1, 5'd31, 1'b0, OStall};
    vecs[9] = '{"no_match",     5'd8,  5'd10, 1'b1, 1'b1, 5'd9,  1'b0, ONorm};

    // Reset held with a hazard and a branch present: outputs forced.
    reset_n = 1'b0;
    set_hazard(1'b1);
    sample();
    chk("rst_forced_d1", 32'(o1), 32'(ORst));
    chk("rst_forced_d4", 32'(o4), 32'(ORst));
    next_cycle();
    clear_inputs();
    reset_n = 1'b1;
    sample();
    chk("rst_release_d1", 32'(o1), 32'(ONorm));
    chk("rst_release_d3", 32'(o3), 32'(ONorm));

    // Single-cycle decode table on the LOAD_STALL_CYCLES=1 instance.
    for (int i = 0; i < 10; i++) begin
      next_cycle();
      id_rs = vecs[i].rs; id_rt = vecs[i].rt; id_uses_rt = vecs[i].uses_rt;
      ex_MemRead = vecs[i].mem_read; ex_rt = vecs[i].exrt;
      mem_branch_taken = vecs[i].br;
      sample();
      chk(vecs[i].name, 32'(o1), 32'(vecs[i].exp));
    end

    // One-cycle hazard pulse: 1, 3 and 4 bubbles respectively.
    do_reset();
    set_hazard(1'b0);
    sample();
    chk("pulse_c1_d1", 32'(o1), 32'(OStall));
    chk("pulse_c1_d3", 32'(o3), 32'(OStall));
    next_cycle();
    clear_inputs();
    sample();
    chk("pulse_c2_d1", 32'(o1), 32'(ONorm));
    chk("pulse_c2_d3", 32'(o3), 32'(OStall));
    next_cycle();
    sample();
    chk("pulse_c3_d3", 32'(o3), 32'(OStall));
    chk("pulse_c3_d4", 32'(o4), 32'(OStall));
    next_cycle();
    sample();
    chk("pulse_c4_d3", 32'(o3), 32'(ONorm));
    chk("pulse_c4_d4", 32'(o4), 32'(OStall));
    next_cycle();
    sample();
    chk("pulse_c5_d4", 32'(o4), 32'(ONorm));

    // Branch in the second stall cycle abandons the stall.
    do_reset();
    set_hazard(1'b0);
    sample();
    chk("brk_c1_d3", 32'(o3), 32'(OStall));
    next_cycle();
    clear_inputs();
    mem_branch_taken = 1'b1;
    sample();
    chk("brk_c2_d3", 32'(o3), 32'(OFlush));
    next_cycle();
    mem_branch_taken = 1'b0;
    sample();
    chk("brk_c3_d3", 32'(o3), 32'(ONorm));
    chk("brk_c3_d4", 32'(o4), 32'(ONorm));

    // Hazard and branch together: flush only, no STALL entry.
    do_reset();
    set_hazard(1'b1);
    sample();
    chk("simul_c1_d3", 32'(o3), 32'(OFlush));
    next_cycle();
    clear_inputs();
    sample();
    chk("simul_c2_d3", 32'(o3), 32'(ONorm));
    chk("simul_c2_d4", 32'(o4), 32'(ONorm));
`ifdef HAZARD_UNIT_STATS_EN
    chk("simul_flush_count", fc3, 32'd1);
    chk("simul_stall_cycles", sc3, 32'd0);
`endif

    // Reset pulsed in the middle of a four-cycle stall.
    do_reset();
    set_hazard(1'b0);
    sample();
    chk("midrst_c1_d4", 32'(o4), 32'(OStall));
    next_cycle();
    clear_inputs();
    sample();
    chk("midrst_c2_d4", 32'(o4), 32'(OStall));
    #2;
    reset_n = 1'b0;
    #1;
    chk("midrst_forced_d4", 32'(o4), 32'(ORst));
    next_cycle();
    reset_n = 1'b1;
    sample();
    chk("midrst_after1_d4", 32'(o4), 32'(ONorm));
    next_cycle();
    sample();
    chk("midrst_after2_d4", 32'(o4), 32'(ONorm));
`ifdef HAZARD_UNIT_STATS_EN
    chk("midrst_stall_cycles", sc4, 32'd0);
    chk("midrst_flush_count", fc4, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
